msg_serializer: RTL and testbench

MSG_SERIALIZER -- requirements
Module: msg_serializer

---
 rtl/math_pkg.sv | 21 ++
 rtl/msg_serializer.sv | 91 +++++++++
 tb/tb_msg_serializer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared elaboration-time arithmetic helpers for width and count derivation.
package math_pkg;

    // Smallest n such that 2**n >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of word_width-bit words needed to carry size bits.
    function automatic int get_word_count_for_size(input int size, input int word_width);
        return (size + word_width - 1) / word_width;
    endfunction

endpackage

// File: rtl/msg_serializer.sv
// Message serializer: accepts one MSG_WIDTH-bit message and emits it as
// N_WORDS words of WORD_WIDTH bits, least significant word first, over a
// valid/ready stream. A new message may be accepted on the handshake of
// the final word so back-to-back messages stream without a bubble.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | no message held, in_ready high
//   ST_SEND | message held, word idx_q presented on out_data
module msg_serializer
    import math_pkg::*;
#(
    parameter  int MSG_WIDTH  = 64,
    parameter  int WORD_WIDTH = 16,
    localparam int N_WORDS    = get_word_count_for_size(MSG_WIDTH, WORD_WIDTH),
    localparam int IDX_W      = (clog2(N_WORDS) > 1) ? clog2(N_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MSG_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [IDX_W-1:0]      out_index
);

    // Holding register is padded to whole words so the last word's upper
    // bits are naturally zero and every word is a plain low-slice read.
    localparam int               PAD_W     = N_WORDS * WORD_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_WORDS - 1);
    localparam logic             LOAD_LAST = (N_WORDS == 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               last_q;
    logic [PAD_W-1:0]   hold_q;

    logic               word_taken;
    logic               load;
    logic [IDX_W-1:0]   idx_d;
    logic [PAD_W-1:0]   hold_d;

    // Handshake decode; in_ready reopens on the final word's handshake.
    always_comb begin
        word_taken = (state_q == ST_SEND) && out_ready;
        in_ready   = (state_q == ST_IDLE) || (word_taken && last_q);
        load       = in_valid && in_ready;
        idx_d      = idx_q + IDX_W'(1);
        hold_d     = hold_q >> WORD_WIDTH;
    end

    // Serializer FSM: load, advance through words, return to idle or reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= 1'b0;
            hold_q  <= '0;
        end else if (load) begin
            state_q <= ST_SEND;
            idx_q   <= '0;
            last_q  <= LOAD_LAST;
            hold_q  <= PAD_W'(in_data);
        end else if (word_taken) begin
            if (last_q) begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                last_q  <= 1'b0;
                hold_q  <= '0;
            end else begin
                idx_q   <= idx_d;
                last_q  <= (idx_d == LAST_IDX);
                hold_q  <= hold_d;
            end
        end
    end

    assign out_valid = (state_q == ST_SEND);
    assign out_data  = hold_q[WORD_WIDTH-1:0];
    assign out_last  = last_q;
    assign out_index = idx_q;

endmodule

// File: tb/tb_msg_serializer.sv
// Bench for msg_serializer: a 40/16 instance under directed and random
// traffic checked against a word-queue model, plus 32/16 and 8/16 instances.
module tb_msg_serializer;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [39:0] a_in_data;
    logic [15:0] a_out_data;
    logic [1:0]  a_out_index;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_data;
    logic [15:0] b_out_data;
    logic [0:0]  b_out_index;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [7:0]  c_in_data;
    logic [15:0] c_out_data;
    logic [0:0]  c_out_index;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [15:0] data;
        int          idx;
        logic        last;
    } word_t;

    localparam int A_WORDS = (40 + 16 - 1) / 16;
    word_t sb_q[$];

    msg_serializer #(.MSG_WIDTH(40), .WORD_WIDTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_index(a_out_index)
    );

    msg_serializer #(.MSG_WIDTH(32), .WORD_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_index(b_out_index)
    );

    msg_serializer #(.MSG_WIDTH(8), .WORD_WIDTH(16)) u_dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_last(c_out_last), .out_index(c_out_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a message becomes A_WORDS words, word k = (msg >> 16k) mod 2^16.
    function automatic void push_msg(input logic [39:0] msg);
        word_t w;
        for (int k = 0; k < A_WORDS; k++) begin
            w.data = 16'(msg >> (16 * k));
            w.idx  = k;
            w.last = (k == A_WORDS - 1);
            sb_q.push_back(w);
        end
    endfunction

    // Scoreboard for instance A, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            check_val("a_out_valid", 64'(a_out_valid), 64'(sb_q.size() != 0));
            check_val("a_in_ready", 64'(a_in_ready),
                      64'((sb_q.size() == 0) || (sb_q.size() == 1 && a_out_ready)));
            if (a_out_valid && sb_q.size() != 0) begin
                check_val("a_out_data", 64'(a_out_data), 64'(sb_q[0].data));
                check_val("a_out_index", 64'(a_out_index), 64'(sb_q[0].idx));
                check_val("a_out_last", 64'(a_out_last), 64'(sb_q[0].last));
            end
            if (a_out_valid && a_out_ready && sb_q.size() != 0) begin
                sb_q.delete(0);
            end
            if (a_in_valid && a_in_ready) begin
                push_msg(a_in_data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        acc;
        logic [15:0] exp_w [6];

        rst_n = 1'b1;
        a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        c_in_valid = 0; c_out_ready = 0; c_in_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_a_valid", 64'(a_out_valid), 64'd0);
        check_val("rst_a_index", 64'(a_out_index), 64'd0);
        check_val("rst_a_last", 64'(a_out_last), 64'd0);
        check_val("rst_a_data", 64'(a_out_data), 64'd0);
        check_val("rst_b_valid", 64'(b_out_valid), 64'd0);
        check_val("rst_c_last", 64'(c_out_last), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 40/16 basic streaming with out_ready held high
        a_out_ready = 1; a_in_data = 40'h123456789A; a_in_valid = 1;
        step(); a_in_valid = 0;
        @(negedge clk);
        check_val("t1_w0", 64'(a_out_data), 64'h789A);
        check_val("t1_i0", 64'(a_out_index), 64'd0);
        check_val("t1_l0", 64'(a_out_last), 64'd0);
        step(); @(negedge clk);
        check_val("t1_w1", 64'(a_out_data), 64'h3456);
        check_val("t1_i1", 64'(a_out_index), 64'd1);
        step(); @(negedge clk);
        check_val("t1_w2", 64'(a_out_data), 64'h0012);
        check_val("t1_i2", 64'(a_out_index), 64'd2);
        check_val("t1_l2", 64'(a_out_last), 64'd1);
        step(); @(negedge clk);
        check_val("t1_idle", 64'(a_out_valid), 64'd0);

        // Backpressure for two cycles at index 1
        step();
        a_in_data = 40'h123456789A; a_in_valid = 1;
        step(); a_in_valid = 0;
        step(); a_out_ready = 0;
        repeat (2) begin
            @(negedge clk);
            check_val("t2_hold_w", 64'(a_out_data), 64'h3456);
            check_val("t2_hold_i", 64'(a_out_index), 64'd1);
            check_val("t2_hold_v", 64'(a_out_valid), 64'd1);
            step();
        end
        a_out_ready = 1;
        @(negedge clk);
        check_val("t2_resume_w", 64'(a_out_data), 64'h3456);
        step(); @(negedge clk);
        check_val("t2_w2", 64'(a_out_data), 64'h0012);
        check_val("t2_l2", 64'(a_out_last), 64'd1);
        step();

        // Back-to-back messages with in_valid held: six words, no gap
        exp_w[0] = 16'h0D0E; exp_w[1] = 16'h0B0C; exp_w[2] = 16'h000A;
        exp_w[3] = 16'h1415; exp_w[4] = 16'h1213; exp_w[5] = 16'h0011;
        a_in_data = 40'h0A0B0C0D0E; a_in_valid = 1;
        step(); a_in_data = 40'h1112131415;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("t3_valid", 64'(a_out_valid), 64'd1);
            check_val("t3_word", 64'(a_out_data), 64'(exp_w[i]));
            if (i < 2) check_val("t3_busy", 64'(a_in_ready), 64'd0);
            if (i == 2) check_val("t3_reload", 64'(a_in_ready), 64'd1);
            step();
            if (i == 2) a_in_valid = 0;
        end
        @(negedge clk);
        check_val("t3_idle", 64'(a_out_valid), 64'd0);

        // 32/16: exact fit, two words
        step();
        b_out_ready = 1; b_in_data = 32'hDEADBEEF; b_in_valid = 1;
        step(); b_in_valid = 0;
        @(negedge clk);
        check_val("b_w0", 64'(b_out_data), 64'hBEEF);
        check_val("b_i0", 64'(b_out_index), 64'd0);
        check_val("b_l0", 64'(b_out_last), 64'd0);
        step(); @(negedge clk);
        check_val("b_w1", 64'(b_out_data), 64'hDEAD);
        check_val("b_i1", 64'(b_out_index), 64'd1);
        check_val("b_l1", 64'(b_out_last), 64'd1);
        step(); @(negedge clk);
        check_val("b_idle", 64'(b_out_valid), 64'd0);

        // 8/16: single zero-padded word, held under backpressure
        step();
        c_out_ready = 0; c_in_data = 8'hAB; c_in_valid = 1;
        step(); c_in_valid = 0;
        @(negedge clk);
        check_val("c_w0", 64'(c_out_data), 64'h00AB);
        check_val("c_l0", 64'(c_out_last), 64'd1);
        check_val("c_i0", 64'(c_out_index), 64'd0);
        check_val("c_busy", 64'(c_in_ready), 64'd0);
        step(); c_out_ready = 1;
        @(negedge clk);
        check_val("c_hold", 64'(c_out_data), 64'h00AB);
        check_val("c_reload_rdy", 64'(c_in_ready), 64'd1);
        step(); @(negedge clk);
        check_val("c_idle", 64'(c_out_valid), 64'd0);

        // Reset mid-message at index 1
        step();
        a_out_ready = 1; a_in_data = 40'h123456789A; a_in_valid = 1;
        step(); a_in_valid = 0;
        step();
        check_val("t4_pre_idx", 64'(a_out_index), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check_val("t4_async_valid", 64'(a_out_valid), 64'd0);
        check_val("t4_async_idx", 64'(a_out_index), 64'd0);
        check_val("t4_async_last", 64'(a_out_last), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("t4_rdy_after", 64'(a_in_ready), 64'd1);
        repeat (3) begin
            step(); @(negedge clk);
            check_val("t4_no_word2", 64'(a_out_valid), 64'd0);
        end

        // Random traffic on A against the scoreboard
        step();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            step();
            a_out_ready = ($urandom_range(0, 3) != 0);
            if (!a_in_valid || acc) begin
                if ($urandom_range(0, 2) != 0) begin
                    a_in_valid = 1;
                    a_in_data  = 40'({$urandom(), $urandom()});
                end else begin
                    a_in_valid = 0;
                end
            end
        end
        a_in_valid = 0;
        a_out_ready = 1;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check_val("a_drain", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        check_val("a_final_idle", 64'(a_out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
